// File: rtl/ups_dac_spi.sv
// SPI serializer for a dual-channel 12-bit DAC with per-channel buffering.
// Define UPS_DAC_LDAC_EN to build the synchronous LDAC update pulse.
module ups_dac_spi #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_HOLD  = 2,
    parameter bit          GAIN_1X  = 1'b1,
    parameter bit          VREF_BUF = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] dac0,
    input  logic        dac0_dv,
    input  logic [11:0] dac1,
    input  logic        dac1_dv,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        dac_ldac_n,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
`ifdef UPS_DAC_LDAC_EN
        LDAC,
`endif
        CSH
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] HOLD_LAST = 8'(CS_HOLD - 1);

    state_t      state, state_nx;
    logic [11:0] hold0, hold1;
    logic        pend0, pend1;
    logic [15:0] sreg, frame;
    logic [7:0]  div_cnt, hold_cnt;
    logic [3:0]  bit_cnt;
    logic        sel, load, load0, load1;
    logic        in_shift, in_hold, phase_end, hold_end;

    assign sel       = ~pend0;
    assign frame     = {sel, VREF_BUF, GAIN_1X, 1'b1, sel ? hold1 : hold0};
    assign phase_end = (div_cnt == DIV_LAST);
    assign hold_end  = (hold_cnt == HOLD_LAST);
    assign in_shift  = (state == LOAD) || (state == SHIFT);
    assign load0     = load & ~sel;
    assign load1     = load & sel;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // The frame is copied on the edge that enters LOAD so that cs_n and
    // bit 15 are already on the pins for the whole LOAD cycle.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        in_hold  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend0 | pend1) begin
                    state_nx = LOAD;
                    load     = 1'b1;
                end
            end
            LOAD:  state_nx = SHIFT;
            SHIFT: begin
                if (phase_end && spi_sclk && bit_cnt == 4'd15)
                    state_nx = CSH;
            end
            CSH: begin
                in_hold = 1'b1;
                if (hold_end) begin
                    if (pend0 | pend1) begin
                        state_nx = LOAD;
                        load     = 1'b1;
                    end else begin
`ifdef UPS_DAC_LDAC_EN
                        state_nx = LDAC;
`else
                        state_nx = IDLE;
`endif
                    end
                end
            end
`ifdef UPS_DAC_LDAC_EN
            LDAC: begin
                in_hold = 1'b1;
                if (hold_end) state_nx = IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold0    <= '0;
            hold1    <= '0;
            pend0    <= 1'b0;
            pend1    <= 1'b0;
            overrun  <= 1'b0;
            spi_cs_n <= 1'b1;
            hold_cnt <= '0;
        end else begin
            if (dac0_dv) begin
                hold0 <= dac0;
                pend0 <= 1'b1;
            end else if (load0) begin
                pend0 <= 1'b0;
            end
            if (dac1_dv) begin
                hold1 <= dac1;
                pend1 <= 1'b1;
            end else if (load1) begin
                pend1 <= 1'b0;
            end
            overrun  <= (dac0_dv & pend0 & ~load0) | (dac1_dv & pend1 & ~load1);
            spi_cs_n <= !(state_nx == LOAD || state_nx == SHIFT);
            if (in_hold && !hold_end) hold_cnt <= hold_cnt + 8'd1;
            else                      hold_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg     <= '0;
            spi_mosi <= 1'b0;
            spi_sclk <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
        end else if (load) begin
            sreg     <= frame;
            spi_mosi <= frame[15];
            spi_sclk <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
        end else if (in_shift) begin
            if (!phase_end) begin
                div_cnt <= div_cnt + 8'd1;
            end else begin
                div_cnt <= '0;
                if (!spi_sclk) begin
                    spi_sclk <= 1'b1;
                end else begin
                    spi_sclk <= 1'b0;
                    if (bit_cnt == 4'd15) begin
                        spi_mosi <= 1'b0;
                    end else begin
                        bit_cnt  <= bit_cnt + 4'd1;
                        sreg     <= {sreg[14:0], 1'b0};
                        spi_mosi <= sreg[14];
                    end
                end
            end
        end
    end

`ifdef UPS_DAC_LDAC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dac_ldac_n <= 1'b1;
        else     dac_ldac_n <= (state_nx != LDAC);
    end
`else
    assign dac_ldac_n = 1'b0;
`endif

endmodule

// File: tb/tb_ups_dac_spi.sv
// Bench for ups_dac_spi: vector table plus corner-case sequences,
// with a bus monitor that decodes frames against a scoreboard queue.
module tb_ups_dac_spi;

    localparam int CLK_DIV = 2;
    localparam int CS_HOLD = 3;
`ifdef UPS_DAC_LDAC_EN
    localparam logic LDAC_RST = 1'b1;
`else
    localparam logic LDAC_RST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] dac0 = '0, dac1 = '0;
    logic        dac0_dv = 1'b0, dac1_dv = 1'b0;
    logic        spi_sclk, spi_mosi, spi_cs_n, dac_ldac_n, busy, overrun;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] sb[$];

    ups_dac_spi #(.CLK_DIV(CLK_DIV), .CS_HOLD(CS_HOLD)) dut (
        .clk(clk), .rst(rst),
        .dac0(dac0), .dac0_dv(dac0_dv),
        .dac1(dac1), .dac1_dv(dac1_dv),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .dac_ldac_n(dac_ldac_n), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Bus monitor, sampled on the falling clock edge.
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_ldac = LDAC_RST;
    logic [15:0] shreg = '0;
    int bitn = 0, low_cnt = 0, high_cnt = 0, last_gap = 0;
    int frames_seen = 0, sclk_rises = 0, ov_cnt = 0;
    int ldac_pulses = 0, ldac_cur = 0, ldac_len = 0, ldac_at = 0;
    bit busy_bad = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_cs   = 1'b1;
            prev_sclk = 1'b0;
            prev_ldac = LDAC_RST;
            bitn      = 0;
            high_cnt  = 0;
        end else begin
            if (prev_cs && !spi_cs_n) begin
                last_gap = high_cnt;
                low_cnt  = 0;
                bitn     = 0;
                busy_bad = 1'b0;
            end
            if (!prev_cs && spi_cs_n) begin
                frames_seen++;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL frame_unexpected: got %h required none", shreg);
                end else begin
                    chk("frame", shreg, sb.pop_front());
                end
                chk("cs_low_len", 16'(low_cnt), 16'(32 * CLK_DIV));
                chk("busy_in_frame", {15'd0, busy_bad}, 16'd0);
                high_cnt = 0;
            end
            if (!spi_cs_n) begin
                low_cnt++;
                if (!busy) busy_bad = 1'b1;
            end else begin
                high_cnt++;
            end
            if (!prev_sclk && spi_sclk) begin
                sclk_rises++;
                if (!spi_cs_n) begin
                    shreg = {shreg[14:0], spi_mosi};
                    bitn++;
                end
            end
            if (overrun) ov_cnt++;
            if (prev_ldac && !dac_ldac_n) begin
                ldac_pulses++;
                ldac_cur = 0;
                ldac_at  = frames_seen;
            end
            if (!dac_ldac_n) ldac_cur++;
            if (!prev_ldac && dac_ldac_n) ldac_len = ldac_cur;
            prev_cs   = spi_cs_n;
            prev_sclk = spi_sclk;
            prev_ldac = dac_ldac_n;
        end
    end

    task automatic strobe(input bit v0, input logic [11:0] a,
                          input bit v1, input logic [11:0] b);
        dac0_dv = v0; dac0 = a;
        dac1_dv = v1; dac1 = b;
        @(posedge clk); #1;
        dac0_dv = 1'b0;
        dac1_dv = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sb.size() != 0) && n < 2000);
        if (n >= 2000) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got busy=%0b queued=%0d required idle",
                     nm, busy, sb.size());
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          ch;
        logic [11:0] data;
        logic [15:0] frame;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int ov0, rises, n, p0;
        tbl[0] = '{1'b0, 12'hABC, 16'h3ABC};
        tbl[1] = '{1'b1, 12'h456, 16'hB456};
        tbl[2] = '{1'b0, 12'h000, 16'h3000};
        tbl[3] = '{1'b1, 12'hFFF, 16'hBFFF};
        tbl[4] = '{1'b0, 12'h5A5, 16'h35A5};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", {15'd0, spi_cs_n}, 16'd1);
        chk("rst_sclk", {15'd0, spi_sclk}, 16'd0);
        chk("rst_mosi", {15'd0, spi_mosi}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_overrun", {15'd0, overrun}, 16'd0);
        chk("rst_ldac_n", {15'd0, dac_ldac_n}, {15'd0, LDAC_RST});
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            sb.push_back(tbl[i].frame);
            strobe(!tbl[i].ch, tbl[i].data, tbl[i].ch, tbl[i].data);
            chk("cs_before_load", {15'd0, spi_cs_n}, 16'd1);
            @(posedge clk); #1;
            chk("dv_to_cs_fall", {15'd0, spi_cs_n}, 16'd0);
            wait_idle("table");
        end
        chk("no_overrun_yet", 16'(ov_cnt), 16'd0);

        // Both channels in one cycle: ch0 first, then minimum cs_n gap.
        p0 = ldac_pulses;
        n  = frames_seen;
        sb.push_back(16'h3123);
        sb.push_back(16'hB456);
        strobe(1'b1, 12'h123, 1'b1, 12'h456);
        wait_idle("dual");
        chk("b2b_cs_gap", 16'(last_gap), 16'(CS_HOLD));
`ifdef UPS_DAC_LDAC_EN
        chk("ldac_pulses", 16'(ldac_pulses - p0), 16'd1);
        chk("ldac_len", 16'(ldac_len), 16'(CS_HOLD));
        chk("ldac_after_2nd", 16'(ldac_at - n), 16'd2);
`else
        chk("ldac_none", 16'(ldac_pulses - p0 + frames_seen - n), 16'd2);
`endif

        // Overwrite of an unsent ch1 word while a ch0 frame is on the wire.
        ov0 = ov_cnt;
        sb.push_back(16'h30F0);
        sb.push_back(16'hB222);
        strobe(1'b1, 12'h0F0, 1'b0, 12'h000);
        repeat (4) @(posedge clk);
        #1;
        strobe(1'b0, 12'h000, 1'b1, 12'h111);
        repeat (3) @(posedge clk);
        #1;
        strobe(1'b0, 12'h000, 1'b1, 12'h222);
        chk("overrun_pulse", {15'd0, overrun}, 16'd1);
        wait_idle("overrun");
        chk("overrun_count", 16'(ov_cnt - ov0), 16'd1);

        // Second ch0 word arrives while the first is being loaded.
        ov0 = ov_cnt;
        sb.push_back(16'h3001);
        sb.push_back(16'h37FF);
        strobe(1'b1, 12'h001, 1'b0, 12'h000);
        @(posedge clk); #1;
        strobe(1'b1, 12'h7FF, 1'b0, 12'h000);
        wait_idle("load_race");
        chk("load_race_ov", 16'(ov_cnt - ov0), 16'd0);

        // Reset in the middle of a frame with a ch1 word pending.
        sb.push_back(16'h3555);
        strobe(1'b1, 12'h555, 1'b0, 12'h000);
        strobe(1'b0, 12'h000, 1'b1, 12'h999);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (bitn < 9 && n < 500);
        chk("reach_bit7", 16'(bitn), 16'd9);
        #2 rst = 1'b1;
        #1;
        chk("arst_cs_n", {15'd0, spi_cs_n}, 16'd1);
        chk("arst_sclk", {15'd0, spi_sclk}, 16'd0);
        chk("arst_mosi", {15'd0, spi_mosi}, 16'd0);
        chk("arst_busy", {15'd0, busy}, 16'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rises = sclk_rises;
        repeat (50) @(posedge clk);
        #1;
        chk("post_rst_sclk", 16'(sclk_rises - rises), 16'd0);
        chk("post_rst_busy", {15'd0, busy}, 16'd0);
        chk("post_rst_cs_n", {15'd0, spi_cs_n}, 16'd1);
`ifndef UPS_DAC_LDAC_EN
        chk("ldac_tied", {15'd0, dac_ldac_n}, 16'd0);
`endif
        chk("sb_drained", 16'(sb.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
